inv_key_schedule: RTL and testbench
===================================

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 key_in  input  128  AES-128 cipher key; byte 0 = key_in[127:120], word w0 = key_in[127:96].
REQ-004 key_load  input  1  sampled each edge; starts expansion of key_in.
REQ-005 rk_req  input  1  request next round key in decryption order.
REQ-006 rk_rewind  input  1  restart read order at round 10.
REQ-007 busy  output  1  high while expansion in progress.
REQ-008 ready  output  1  high when all 11 round keys are stored and readable.
REQ-009 rk_out  output  128  round key delivered to the inverse round stage; same byte order as key_in.
REQ-010 rk_round  output  4  round index (0..10) of rk_out.
REQ-011 rk_valid  output  1  one-cycle strobe; rk_out/rk_round valid while high.

Function
REQ-012 Storage: 11 x 128-bit round-key registers rk[0..10]; read pointer ptr (4 bits, range 0..10); expansion counter cnt (4 bits).
REQ-013 FSM states: IDLE, EXPAND, READY; encoding free.
REQ-014 IDLE/READY/EXPAND + key_load=1 at edge E0: rk[0]<=key_in, cnt<=1, ptr<=10, state<=EXPAND, busy<=1, ready<=0; key_load takes priority over every other input.
REQ-015 EXPAND, each edge: rk[cnt] <= standard AES-128 expansion of rk[cnt-1] (RotWord, SubWord via forward S-box, XOR Rcon[cnt], chained word XORs), cnt<=cnt+1.
REQ-016 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte of the word.
REQ-017 Edge E10 (the edge computing rk[10]): state<=READY, busy<=0, ready<=1; ready therefore rises exactly 10 cycles after the key_load edge.
REQ-018 rk_req and rk_rewind are ignored in IDLE and EXPAND; rk_valid stays 0.
REQ-019 READY + rk_req=1: next edge rk_out<=rk[ptr], rk_round<=ptr, rk_valid<=1; ptr<=ptr-1, wrapping 0 -> 10.
REQ-020 Read latency: one cycle from sampled rk_req to rk_valid; back-to-back requests are accepted every cycle.
REQ-021 rk_valid is a single-cycle pulse per accepted request; rk_out and rk_round hold their last value when rk_valid=0.
REQ-022 READY + rk_rewind=1, rk_req=0: ptr<=10, no output.
REQ-023 READY + rk_rewind=1 and rk_req=1: serve rk[10], ptr<=9.
REQ-024 READY + key_load=1 with rk_req: no output, rk_valid<=0, restart per REQ-014.
REQ-025 EXPAND + key_load=1: abort current expansion and restart with the new key_in; a partial schedule is never marked ready.
REQ-026 The combinational path from rk registers to rk_out passes through registers only; no combinational input-to-output path.

Reset
REQ-027 rst=1 at an edge: state<=IDLE, busy=0, ready=0, rk_valid=0, rk_out=0, rk_round=0, ptr=10, cnt=0, all rk[] cleared to 0.
REQ-028 rst has priority over key_load, rk_req and rk_rewind; reset mid-EXPAND discards the partial schedule.

Verification
REQ-029 key_in=2b7e151628aed2a6abf7158809cf4f3c, key_load pulse -> busy 10 cycles, ready after 10 cycles; rk_req -> rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 Same key, 11 consecutive rk_req -> rounds 10..0 on consecutive cycles; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = key_in; 12th request -> round 10 again (wrap).
REQ-031 key_in=000102030405060708090a0b0c0d0e0f -> first rk_req yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 Issue key_load at cycle 5 of EXPAND with a second key -> ready 10 cycles after the second load; round 10 matches the second key only.
REQ-033 READY, 3 requests (ptr=7), then rk_rewind+rk_req in the same cycle -> rk_round=10; the next request -> rk_round=9.
REQ-034 rst asserted mid-EXPAND and mid-read -> all outputs 0 next cycle; rk_req before a new key_load -> no rk_valid.

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-128 key schedule that expands a cipher key one round per cycle, stores all
// 11 round keys, and replays them in decryption order (round 10 down to round 0).
module inv_key_schedule (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] key_in_i,
  input  logic         key_load_i,
  input  logic         rk_req_i,
  input  logic         rk_rewind_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [127:0] rk_out_o,
  output logic [3:0]   rk_round_o,
  output logic         rk_valid_o
);

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  // Forward S-box, row-major; byte 0x00 sits in the most significant byte.
  localparam logic [2047:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return Sbox[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    unique case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] expand_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   ptr_q, ptr_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic [3:0]   prev_idx;
  logic [3:0]   rd_idx;
  logic [127:0] next_key;

  always_comb begin
    prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    next_key = expand_step(rk_q[prev_idx], rcon(cnt_q));
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    round_d = round_q;
    valid_d = 1'b0;
    // A rewind in the same cycle as a request serves round 10 directly.
    rd_idx  = rk_rewind_i ? 4'd10 : ptr_q;
    if (key_load_i) begin
      rk_d[0] = key_in_i;
      cnt_d   = 4'd1;
      ptr_d   = 4'd10;
      state_d = StExpand;
    end else begin
      unique case (state_q)
        StExpand: begin
          if (cnt_q >= 4'd1 && cnt_q <= 4'd10) rk_d[cnt_q] = next_key;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd10) state_d = StReady;
        end
        StReady: begin
          if (rk_req_i) begin
            out_d   = rk_q[rd_idx];
            round_d = rd_idx;
            valid_d = 1'b1;
            ptr_d   = (rd_idx == 4'd0) ? 4'd10 : rd_idx - 4'd1;
          end else if (rk_rewind_i) begin
            ptr_d = 4'd10;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ptr_q   <= 4'd10;
      out_q   <= '0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      round_q <= round_d;
      valid_q <= valid_d;
      rk_q    <= rk_d;
    end
  end

  assign busy_o     = (state_q == StExpand);
  assign ready_o    = (state_q == StReady);
  assign rk_out_o   = out_q;
  assign rk_round_o = round_q;
  assign rk_valid_o = valid_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: directed spec vectors plus random traffic, checked against
// a model whose S-box is derived from GF(2^8) inversion and the FIPS-197 word recurrence.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         rk_req = 1'b0;
  logic         rk_rewind = 1'b0;
  logic         busy, ready, rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  int vectors = 0;
  int miscompares = 0;

  inv_key_schedule dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .key_in_i   (key_in),
    .key_load_i (key_load),
    .rk_req_i   (rk_req),
    .rk_rewind_i(rk_rewind),
    .busy_o     (busy),
    .ready_o    (ready),
    .rk_out_o   (rk_out),
    .rk_round_o (rk_round),
    .rk_valid_o (rk_valid)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0]   sbox_tab [256];
  logic [127:0] m_keys [11];
  int           m_mode = 0;  // 0 idle, 1 expanding, 2 ready
  int           m_age = 0;
  int           m_ptr = 10;
  logic [127:0] m_out = '0;
  logic [3:0]   m_round = '0;
  bit           m_valid = 1'b0;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] make_sbox(input logic [7:0] x);
    logic [7:0] inv = x;
    for (int i = 0; i < 253; i++) inv = gmul(inv, x);  // x^254 is the field inverse
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic compute_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic model_edge(input bit ld, input bit rq, input bit rw, input bit rs,
                            input logic [127:0] k);
    int r;
    m_valid = 1'b0;
    if (rs) begin
      m_mode = 0; m_ptr = 10; m_out = '0; m_round = '0;
    end else if (ld) begin
      compute_schedule(k);
      m_mode = 1; m_age = 0; m_ptr = 10;
    end else if (m_mode == 1) begin
      m_age++;
      if (m_age == 10) m_mode = 2;
    end else if (m_mode == 2) begin
      if (rq) begin
        r = rw ? 10 : m_ptr;
        m_out = m_keys[r];
        m_round = 4'(r);
        m_valid = 1'b1;
        m_ptr = (r == 0) ? 10 : r - 1;
      end else if (rw) begin
        m_ptr = 10;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit ld, input bit rq, input bit rw, input bit rs,
                      input logic [127:0] k);
    key_load = ld; rk_req = rq; rk_rewind = rw; rst = rs; key_in = k;
    @(posedge clk);
    model_edge(ld, rq, rw, rs, k);
    #1;
    cmp("busy", 128'(busy), 128'(m_mode == 1));
    cmp("ready", 128'(ready), 128'(m_mode == 2));
    cmp("rk_valid", 128'(rk_valid), 128'(m_valid));
    cmp("rk_round", 128'(rk_round), 128'(m_round));
    cmp("rk_out", rk_out, m_out);
    key_load = 1'b0; rk_req = 1'b0; rk_rewind = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] KeyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyB = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = make_sbox(8'(i));

    // Reset state, then a request with no key loaded must not produce output.
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 0, '0);
    step(0, 1, 1, 0, '0);

    // Expansion of the FIPS-197 key; requests during expansion are ignored.
    step(1, 0, 0, 0, KeyA);
    for (int i = 0; i < 10; i++) step(0, i[0], i[1], 0, '0);
    cmp("ready_after_10", 128'(ready), 128'(1));

    // Twelve back-to-back reads: rounds 10..0 then wrap to 10.
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, '0);
      if (i == 0) cmp("keyA_round10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      if (i == 9) cmp("keyA_round1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
      if (i == 10) cmp("keyA_round0", rk_out, KeyA);
      if (i == 11) cmp("wrap_round", 128'(rk_round), 128'(10));
    end
    step(0, 0, 0, 0, '0);

    // Rewind alone, three reads, then rewind with request, then one more read.
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    cmp("rewind_req_round", 128'(rk_round), 128'(10));
    step(0, 1, 0, 0, '0);
    cmp("after_rewind_round", 128'(rk_round), 128'(9));

    // Second known-answer key, loaded while READY with a request pending.
    step(1, 1, 0, 0, KeyB);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    cmp("keyB_round10", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Abort a running expansion with a second key, then read the full schedule.
    step(1, 0, 0, 0, rand_key());
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, rand_key());
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, '0);

    // Reset mid-expansion and mid-read.
    step(1, 0, 0, 0, rand_key());
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, rand_key());
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 1, '0);
    cmp("rst_clears_out", rk_out, 128'h0);
    step(0, 1, 0, 0, '0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0), rand_key());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
